bio_half_duplex_ctrl: RTL and testbench



---
 rtl/bio_ctrl_pkg.sv | 35 +++
 rtl/bio_half_duplex_ctrl_bit_timer.sv | 79 +++++++
 rtl/bio_half_duplex_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bio_half_duplex_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bio_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bio_ctrl_pkg
//
// Purpose:
//   Shared definitions for the half-duplex bidirectional pad controller:
//   the FSM state encoding, the default timing constants, and a small helper
//   that sizes counters so that a constant of 1 still yields a legal width.
//
// Contents:
//   state_e          IDLE=0, TX=1, TURN=2, RX=3
//   DEF_DATA_W       default word width (both directions)
//   DEF_BIT_CYCLES   default clocks per serial bit
//   DEF_TURN_CYCLES  default clocks of released line between TX and RX
//   cnt_width()      $clog2 with a floor of one bit
// ----------------------------------------------------------------------------
package bio_ctrl_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_BIT_CYCLES  = 4;
    localparam int DEF_TURN_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        TURN = 2'd2,
        RX   = 2'd3
    } state_e;

    // $clog2(1) is 0, which would give a zero-width counter; keep at least
    // one bit so degenerate parameter values still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bio_ctrl_pkg

// File: rtl/bio_half_duplex_ctrl_bit_timer.sv
// ----------------------------------------------------------------------------
// bio_bit_timer
//
// Purpose:
//   Serial bit timing for one phase (TX or RX) of a half-duplex transaction.
//   Counts BIT_CYCLES clocks per bit and DATA_W bits per word, and flags the
//   interesting points inside that sequence.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   clear          return both counters to 0 (held while no phase is active)
//   run            advance the counters this cycle
//   bit_end        last clock of the current bit period
//   sample_strobe  mid-bit clock (index BIT_CYCLES/2) of the current bit
//   word_end       last clock of the last bit of the word
// ----------------------------------------------------------------------------
module bio_bit_timer
    import bio_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end,
    output logic sample_strobe,
    output logic word_end
);

    localparam int CW = cnt_width(BIT_CYCLES);
    localparam int BW = cnt_width(DATA_W + 1);

    localparam logic [CW-1:0] LAST_CYC   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_CYC = CW'(BIT_CYCLES / 2);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] bit_q, bit_d;

    // Strobes are purely combinational from the counters so the FSM sees them
    // in the very cycle they describe.
    always_comb begin
        bit_end       = run && (cyc_q == LAST_CYC);
        sample_strobe = run && (cyc_q == SAMPLE_CYC);
        word_end      = bit_end && (bit_q == LAST_BIT);
    end

    // Counter next-state. The word counter wraps to 0 on word_end so the
    // timer is already clean if the same phase is re-entered directly.
    always_comb begin
        cyc_d = cyc_q;
        bit_d = bit_q;
        if (clear) begin
            cyc_d = '0;
            bit_d = '0;
        end else if (run) begin
            if (bit_end) begin
                cyc_d = '0;
                bit_d = word_end ? '0 : (bit_q + BW'(1));
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            bit_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            bit_q <= bit_d;
        end
    end

endmodule : bio_bit_timer

// File: rtl/bio_half_duplex_ctrl.sv
// ----------------------------------------------------------------------------
// bio_half_duplex_ctrl
//
// Purpose:
//   Sequences a single tri-state pad cell as a half-duplex serial link. A
//   transaction sends a DATA_W-bit word MSB first, releases the wire for
//   TURN_CYCLES clocks, and optionally receives a DATA_W-bit reply. The pad
//   enable is a flop cleared by the asynchronous reset, so the wire is let
//   go the instant reset asserts, and it is only ever set while in TX.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     request a transaction (accepted only while busy=0)
//   rx_req    sampled with start: 1 = TX then RX, 0 = TX only
//   wr_data   word to transmit, captured on acceptance
//   rd_data   last received word (updated only when an RX phase completes)
//   busy      high from the cycle after acceptance until done
//   done      one-cycle pulse at the end of a transaction
//   bio_en    pad cell enable, 1 = drive the wire
//   bio_dout  pad cell data in, bit being transmitted
//   bio_din   pad cell data out, current wire value
// ----------------------------------------------------------------------------
module bio_half_duplex_ctrl
    import bio_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              bio_en,
    output logic              bio_dout,
    input  logic              bio_din
);

    localparam int TW = cnt_width(TURN_CYCLES);
    localparam logic [TW-1:0] LAST_TURN = TW'(TURN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_flag_q, rx_flag_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bio_en_q, bio_en_d;
    logic              bio_dout_q, bio_dout_d;

    logic              timer_run;
    logic              timer_clear;
    logic              bit_end;
    logic              sample_strobe;
    logic              word_end;
    logic [DATA_W-1:0] rx_shift_next;

    // The bit timer only runs during the two serial phases; holding it clear
    // in IDLE and TURN guarantees each phase starts at bit 0, cycle 0.
    always_comb begin
        timer_run   = (state_q == TX) || (state_q == RX);
        timer_clear = !timer_run;
    end

    bio_bit_timer #(
        .DATA_W     (DATA_W),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (timer_clear),
        .run           (timer_run),
        .bit_end       (bit_end),
        .sample_strobe (sample_strobe),
        .word_end      (word_end)
    );

    // Receive shift with this cycle's sample folded in. When BIT_CYCLES is 2
    // the sample point coincides with bit_end, so the word handed to rd_data
    // on word_end must include the bit being sampled in that same cycle.
    always_comb begin
        rx_shift_next = rx_shift_q;
        if (sample_strobe) begin
            rx_shift_next = {rx_shift_q[DATA_W-2:0], bio_din};
        end
    end

    // Next-state logic for the FSM and datapath. The pad-facing outputs and
    // busy are derived from the next state so that they are registered and
    // line up exactly with the state they describe.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_flag_d  = rx_flag_q;
        turn_cnt_d = turn_cnt_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_shift_d = wr_data;
                    rx_flag_d  = rx_req;
                    rx_shift_d = '0;
                    state_d    = TX;
                end
            end

            TX: begin
                if (bit_end) begin
                    tx_shift_d = tx_shift_q << 1;
                    if (word_end) begin
                        if (rx_flag_q) begin
                            turn_cnt_d = '0;
                            state_d    = TURN;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            TURN: begin
                if (turn_cnt_q == LAST_TURN) begin
                    turn_cnt_d = '0;
                    state_d    = RX;
                end else begin
                    turn_cnt_d = turn_cnt_q + TW'(1);
                end
            end

            RX: begin
                rx_shift_d = rx_shift_next;
                if (word_end) begin
                    rd_data_d = rx_shift_next;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bio_en_d   = (state_d == TX);
        bio_dout_d = (state_d == TX) ? tx_shift_d[DATA_W-1] : 1'b0;
        busy_d     = (state_d != IDLE);
    end

    // All controller state. Reset is asynchronous so the pad enable falls
    // immediately, and an aborted transaction never emits done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_flag_q  <= 1'b0;
            turn_cnt_q <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bio_en_q   <= 1'b0;
            bio_dout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_flag_q  <= rx_flag_d;
            turn_cnt_q <= turn_cnt_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bio_en_q   <= bio_en_d;
            bio_dout_q <= bio_dout_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bio_en   = bio_en_q;
    assign bio_dout = bio_dout_q;

endmodule : bio_half_duplex_ctrl

// File: tb/tb_bio_half_duplex_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bio_half_duplex_ctrl
//
// Drives the controller through reset, TX-only, TX+RX, ignored start,
// back-to-back and mid-transaction reset scenarios. The pad cell and the far
// end are modelled together: the wire carries bio_dout when the controller
// drives, the far-end bit when the far end drives, and a pull-up otherwise.
// Expected done timing and rd_data are queued when a start is issued and
// popped when done is seen. Cycle k counts negedges after the one on which
// start was raised, so k=1 is the first cycle after the accept edge.
// ----------------------------------------------------------------------------
module tb_bio_half_duplex_ctrl;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int TC = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          rx_req;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          bio_en;
    logic          bio_dout;
    logic          bio_din;

    logic          far_en;
    logic          far_bit;
    logic          far_active;
    logic [DW-1:0] far_word;
    int            far_base;

    typedef struct {
        logic [DW-1:0] rd;
        int            done_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_rd;
    int            k;
    int            compared;
    int            mismatched;

    bio_half_duplex_ctrl #(
        .DATA_W      (DW),
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_req   (rx_req),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .bio_en   (bio_en),
        .bio_dout (bio_dout),
        .bio_din  (bio_din)
    );

    // Pad cell plus far end resolved onto one wire value.
    always_comb begin
        if (bio_en)
            bio_din = bio_dout;
        else if (far_en)
            bio_din = far_bit;
        else
            bio_din = 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and update the far-end driver for that cycle.
    task automatic tick();
        @(negedge clk);
        k = k + 1;
        if (far_active && k >= far_base && k < far_base + DW * BC) begin
            far_en  = 1'b1;
            far_bit = far_word[DW - 1 - (k - far_base) / BC];
        end else begin
            far_en  = 1'b0;
            far_bit = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        rx_req     = 1'b0;
        wr_data    = '0;
        far_active = 1'b0;
        far_en     = 1'b0;
        far_bit    = 1'b0;
        far_word   = '0;
        far_base   = 0;
        k          = 0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bio_en, busy, done} !== 3'b000 || rd_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: en/busy/done/rd=%b/%b/%b/%h required 0/0/0/00",
                     bio_en, busy, done, rd_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if ({bio_en, busy, done} !== 3'b000 || rd_data !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle cycle %0d: en/busy/done/rd=%b/%b/%b/%h required 0/0/0/00",
                         i, bio_en, busy, done, rd_data);
            end
        end
        model_rd = '0;
        sb.delete();
    endtask

    task automatic test_tx_only(input logic [DW-1:0] wd);
        exp_t e;
        int   dones;
        dones      = 0;
        wr_data    = wd;
        rx_req     = 1'b0;
        start      = 1'b1;
        k          = 0;
        e.rd       = model_rd;
        e.done_cyc = 1 + DW * BC;
        sb.push_back(e);
        while (k < 40) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k >= 1 && k <= DW * BC) begin
                compared++;
                if (bio_en !== 1'b1 || busy !== 1'b1 || bio_din !== wd[DW - 1 - (k - 1) / BC]) begin
                    mismatched++;
                    $display("[TB] FAIL tx_bit k=%0d: en/busy/wire=%b/%b/%b required 1/1/%b",
                             k, bio_en, busy, bio_din, wd[DW - 1 - (k - 1) / BC]);
                end
            end else begin
                compared++;
                if (bio_en !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL tx_release k=%0d: en=%b required 0", k, bio_en);
                end
            end
            if (done === 1'b1) begin
                dones++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL tx_unexpected_done k=%0d: got done, required none", k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.done_cyc || rd_data !== e.rd) begin
                        mismatched++;
                        $display("[TB] FAIL tx_done: cycle/rd=%0d/%h required %0d/%h",
                                 k, rd_data, e.done_cyc, e.rd);
                    end
                end
            end
        end
        compared++;
        if (dones != 1) begin
            mismatched++;
            $display("[TB] FAIL tx_done_count: got %0d required 1", dones);
        end
    endtask

    task automatic test_tx_rx(input logic [DW-1:0] wd, input logic [DW-1:0] fw);
        exp_t e;
        int   dones;
        int   done_at;
        dones      = 0;
        done_at    = 1 + 2 * DW * BC + TC;
        wr_data    = wd;
        rx_req     = 1'b1;
        far_word   = fw;
        far_base   = 1 + DW * BC + TC;
        far_active = 1'b1;
        start      = 1'b1;
        k          = 0;
        model_rd   = fw;
        e.rd       = fw;
        e.done_cyc = done_at;
        sb.push_back(e);
        while (k < done_at + 5) begin
            tick();
            if (k == 1) begin
                start  = 1'b0;
                rx_req = 1'b0;
            end
            if (k >= 1 && k <= DW * BC) begin
                compared++;
                if (bio_en !== 1'b1 || bio_din !== wd[DW - 1 - (k - 1) / BC]) begin
                    mismatched++;
                    $display("[TB] FAIL txrx_tx_bit k=%0d: en/wire=%b/%b required 1/%b",
                             k, bio_en, bio_din, wd[DW - 1 - (k - 1) / BC]);
                end
            end else if (k < done_at) begin
                compared++;
                if (bio_en !== 1'b0 || busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL txrx_released k=%0d: en/busy=%b/%b required 0/1",
                             k, bio_en, busy);
                end
            end else begin
                compared++;
                if (bio_en !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL txrx_after k=%0d: en=%b required 0", k, bio_en);
                end
            end
            if (done === 1'b1) begin
                dones++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL txrx_unexpected_done k=%0d: got done, required none", k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.done_cyc || rd_data !== e.rd) begin
                        mismatched++;
                        $display("[TB] FAIL txrx_done: cycle/rd=%0d/%h required %0d/%h",
                                 k, rd_data, e.done_cyc, e.rd);
                    end
                end
            end
        end
        compared++;
        if (dones != 1) begin
            mismatched++;
            $display("[TB] FAIL txrx_done_count: got %0d required 1", dones);
        end
        far_active = 1'b0;
        far_en     = 1'b0;
    endtask

    task automatic test_ignored_start();
        exp_t e;
        int   dones;
        dones      = 0;
        wr_data    = 8'h00;
        rx_req     = 1'b0;
        start      = 1'b1;
        k          = 0;
        e.rd       = model_rd;
        e.done_cyc = 1 + DW * BC;
        sb.push_back(e);
        while (k < 45) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k >= 1 && k <= DW * BC) begin
                compared++;
                if (bio_en !== 1'b1 || bio_din !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL ignored_wire k=%0d: en/wire=%b/%b required 1/0",
                             k, bio_en, bio_din);
                end
            end else begin
                compared++;
                if (bio_en !== 1'b0 || busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL ignored_idle k=%0d: en/busy=%b/%b required 0/0",
                             k, bio_en, busy);
                end
            end
            if (done === 1'b1) begin
                dones++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL ignored_extra_done k=%0d: got done, required none", k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.done_cyc || rd_data !== e.rd) begin
                        mismatched++;
                        $display("[TB] FAIL ignored_done: cycle/rd=%0d/%h required %0d/%h",
                                 k, rd_data, e.done_cyc, e.rd);
                    end
                end
            end
            if (k == 10) begin
                start   = 1'b1;
                wr_data = 8'hFF;
            end else if (k == 11) begin
                start = 1'b0;
            end
        end
        compared++;
        if (dones != 1) begin
            mismatched++;
            $display("[TB] FAIL ignored_done_count: got %0d required 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        int            dones;
        logic          want_en;
        logic          want_bit;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        w1         = 8'h5A;
        w2         = 8'h81;
        dones      = 0;
        wr_data    = w1;
        rx_req     = 1'b0;
        start      = 1'b1;
        k          = 0;
        e.rd       = model_rd;
        e.done_cyc = 1 + DW * BC;
        sb.push_back(e);
        while (k < 72) begin
            tick();
            if (k == 1) start = 1'b0;
            want_en  = (k >= 1 && k <= 32) || (k >= 34 && k <= 65);
            want_bit = 1'b1;
            if (k >= 1 && k <= 32)
                want_bit = w1[DW - 1 - (k - 1) / BC];
            else if (k >= 34 && k <= 65)
                want_bit = w2[DW - 1 - (k - 34) / BC];
            compared++;
            if (bio_en !== want_en || bio_din !== want_bit) begin
                mismatched++;
                $display("[TB] FAIL b2b_wire k=%0d: en/wire=%b/%b required %b/%b",
                         k, bio_en, bio_din, want_en, want_bit);
            end
            if (done === 1'b1) begin
                dones++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_unexpected_done k=%0d: got done, required none", k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.done_cyc || rd_data !== e.rd) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_done: cycle/rd=%0d/%h required %0d/%h",
                                 k, rd_data, e.done_cyc, e.rd);
                    end
                end
                if (dones == 1) begin
                    start      = 1'b1;
                    wr_data    = w2;
                    e.rd       = model_rd;
                    e.done_cyc = k + 1 + DW * BC;
                    sb.push_back(e);
                end
            end
            if (k == 34) start = 1'b0;
        end
        start = 1'b0;
        compared++;
        if (dones != 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_count: got %0d required 2", dones);
        end
    endtask

    task automatic test_midop_reset();
        wr_data    = 8'h3C;
        rx_req     = 1'b1;
        far_word   = 8'hC3;
        far_base   = 1 + DW * BC + TC;
        far_active = 1'b1;
        start      = 1'b1;
        k          = 0;
        while (k < 20) begin
            tick();
            if (k == 1) begin
                start  = 1'b0;
                rx_req = 1'b0;
            end
        end
        compared++;
        if (bio_en !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midop_pre: en/busy=%b/%b required 1/1", bio_en, busy);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({bio_en, busy, done} !== 3'b000 || rd_data !== '0) begin
            mismatched++;
            $display("[TB] FAIL midop_async: en/busy/done/rd=%b/%b/%b/%h required 0/0/0/00",
                     bio_en, busy, done, rd_data);
        end
        far_active = 1'b0;
        sb.delete();
        model_rd = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if ({bio_en, busy, done} !== 3'b000) begin
                mismatched++;
                $display("[TB] FAIL midop_after cycle %0d: en/busy/done=%b/%b/%b required 0/0/0",
                         i, bio_en, busy, done);
            end
        end
        test_tx_rx(8'h3C, 8'hC3);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_tx_only(8'hA5);
        test_tx_rx(8'h3C, 8'hC3);
        test_ignored_start();
        test_back_to_back();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_bio_half_duplex_ctrl
